// File: rtl/dma_lite_pkg.sv
// Shared definitions for the AXI-Lite DMA control-port scheduler:
// register offsets, FSM and job encodings, and the write-sequence table.
package dma_lite_pkg;

  localparam logic [9:0] MM2S_CR     = 10'h000;
  localparam logic [9:0] MM2S_SR     = 10'h004;
  localparam logic [9:0] MM2S_SA     = 10'h018;
  localparam logic [9:0] MM2S_SA_MSB = 10'h01C;
  localparam logic [9:0] MM2S_LENGTH = 10'h028;
  localparam logic [9:0] S2MM_CR     = 10'h030;
  localparam logic [9:0] S2MM_SR     = 10'h034;
  localparam logic [9:0] S2MM_DA     = 10'h048;
  localparam logic [9:0] S2MM_DA_MSB = 10'h04C;
  localparam logic [9:0] S2MM_LENGTH = 10'h058;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RESP, ST_DONE} state_t;

  typedef enum logic [1:0] {JOB_MM2S, JOB_S2MM, JOB_CLR_MM2S, JOB_CLR_S2MM} job_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  // Index of the final write of a job: programming jobs are 4 writes, clears are 1.
  function automatic logic [1:0] job_last(input job_t job);
    return (job == JOB_MM2S || job == JOB_S2MM) ? 2'd3 : 2'd0;
  endfunction

  // Address/data of write number idx within a job.
  function automatic wr_t job_write(input job_t job, input logic [1:0] idx,
                                    input logic [31:0] addr, input logic [25:0] len,
                                    input logic [31:0] cr_data, input logic [31:0] clr_data);
    wr_t w;
    w.addr = '0;
    w.data = '0;
    case (job)
      JOB_MM2S: begin
        case (idx)
          2'd0:    begin w.addr = MM2S_CR;     w.data = cr_data;        end
          2'd1:    begin w.addr = MM2S_SA;     w.data = addr;           end
          2'd2:    begin w.addr = MM2S_SA_MSB; w.data = '0;             end
          default: begin w.addr = MM2S_LENGTH; w.data = {6'b0, len};    end
        endcase
      end
      JOB_S2MM: begin
        case (idx)
          2'd0:    begin w.addr = S2MM_CR;     w.data = cr_data;        end
          2'd1:    begin w.addr = S2MM_DA;     w.data = addr;           end
          2'd2:    begin w.addr = S2MM_DA_MSB; w.data = '0;             end
          default: begin w.addr = S2MM_LENGTH; w.data = {6'b0, len};    end
        endcase
      end
      JOB_CLR_MM2S: begin w.addr = MM2S_SR; w.data = clr_data; end
      default:      begin w.addr = S2MM_SR; w.data = clr_data; end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dma_lite_rr_arb.sv
// Job arbiter: pending interrupt clears first (MM2S before S2MM), then a
// 2-way round-robin between the MM2S and S2MM programming requests.
module dma_lite_rr_arb
  import dma_lite_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pend_mm2s,
  input  logic pend_s2mm,
  input  logic mm2s_req,
  input  logic s2mm_req,
  input  logic take,
  output logic gnt_valid,
  output job_t gnt_job
);

  // 0: MM2S preferred on a tie, 1: S2MM preferred.
  logic ptr;

  // Fixed-priority clears, then round-robin programming grant.
  always_comb begin
    gnt_valid = 1'b1;
    gnt_job   = JOB_MM2S;
    if (pend_mm2s)                 gnt_job = JOB_CLR_MM2S;
    else if (pend_s2mm)            gnt_job = JOB_CLR_S2MM;
    else if (mm2s_req && s2mm_req) gnt_job = ptr ? JOB_S2MM : JOB_MM2S;
    else if (mm2s_req)             gnt_job = JOB_MM2S;
    else if (s2mm_req)             gnt_job = JOB_S2MM;
    else                           gnt_valid = 1'b0;
  end

  // Pointer moves to the other channel after every granted programming job.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (take && gnt_valid && (gnt_job == JOB_MM2S || gnt_job == JOB_S2MM)) begin
      ptr <= (gnt_job == JOB_MM2S);
    end
  end

endmodule

// File: rtl/dma_lite_scheduler.sv
// AXI-Lite write master owning the AXI DMA control port. Serialises MM2S/S2MM
// channel programming (4 writes each) and interrupt clears (1 write each),
// waiting on real AW/W/B handshakes. Optional macro DMA_TIMEOUT_EN bounds the
// B-channel wait to TIMEOUT_CYCLES and reports an error on expiry.
module dma_lite_scheduler
  import dma_lite_pkg::*;
#(
  parameter logic [31:0] CR_DATA        = 32'h00011003,
  parameter logic [31:0] IRQ_CLR_DATA   = 32'h00001000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mm2s_req,
  input  logic [31:0] mm2s_addr,
  input  logic [25:0] mm2s_len,
  output logic        mm2s_done,
  input  logic        s2mm_req,
  input  logic [31:0] s2mm_addr,
  input  logic [25:0] s2mm_len,
  output logic        s2mm_done,
  input  logic        mm2s_introut,
  input  logic        s2mm_introut,
  output logic        busy,
  output logic        err,
  output logic [9:0]  s_axi_lite_awaddr,
  output logic        s_axi_lite_awvalid,
  input  logic        s_axi_lite_awready,
  output logic [31:0] s_axi_lite_wdata,
  output logic        s_axi_lite_wvalid,
  input  logic        s_axi_lite_wready,
  input  logic [1:0]  s_axi_lite_bresp,
  input  logic        s_axi_lite_bvalid,
  output logic        s_axi_lite_bready
);

  state_t      state;
  job_t        job;
  logic [1:0]  idx;
  logic [31:0] job_addr;
  logic [25:0] job_len;
  logic        irq_pend_mm2s, irq_pend_s2mm;
  logic        introut_mm2s_q, introut_s2mm_q;
  logic        gnt_valid;
  job_t        gnt_job;
  logic [31:0] gnt_addr;
  logic [25:0] gnt_len;
  wr_t         gnt_wr, nxt_wr;
  logic        aw_acc, w_acc, b_hs;

`ifdef DMA_TIMEOUT_EN
  logic [31:0] to_cnt;
`endif

  dma_lite_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .pend_mm2s (irq_pend_mm2s),
    .pend_s2mm (irq_pend_s2mm),
    .mm2s_req  (mm2s_req),
    .s2mm_req  (s2mm_req),
    .take      (state == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_job   (gnt_job)
  );

  assign busy = (state != ST_IDLE);
  // A valid already low inside WR means that channel was accepted earlier.
  assign aw_acc = !s_axi_lite_awvalid || s_axi_lite_awready;
  assign w_acc  = !s_axi_lite_wvalid  || s_axi_lite_wready;
  assign b_hs   = s_axi_lite_bvalid && s_axi_lite_bready;

  // First write of the job being granted, and next write of the current job.
  always_comb begin
    gnt_addr = mm2s_addr;
    gnt_len  = mm2s_len;
    if (gnt_job == JOB_S2MM) begin
      gnt_addr = s2mm_addr;
      gnt_len  = s2mm_len;
    end
    gnt_wr = job_write(gnt_job, 2'd0, gnt_addr, gnt_len, CR_DATA, IRQ_CLR_DATA);
    nxt_wr = job_write(job, idx + 2'd1, job_addr, job_len, CR_DATA, IRQ_CLR_DATA);
  end

  // Interrupt edge capture; a new edge coinciding with the clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      introut_mm2s_q <= 1'b0;
      introut_s2mm_q <= 1'b0;
      irq_pend_mm2s  <= 1'b0;
      irq_pend_s2mm  <= 1'b0;
    end else begin
      introut_mm2s_q <= mm2s_introut;
      introut_s2mm_q <= s2mm_introut;
      irq_pend_mm2s  <= (mm2s_introut && !introut_mm2s_q) ||
                        (irq_pend_mm2s && !(state == ST_RESP && b_hs && job == JOB_CLR_MM2S));
      irq_pend_s2mm  <= (s2mm_introut && !introut_s2mm_q) ||
                        (irq_pend_s2mm && !(state == ST_RESP && b_hs && job == JOB_CLR_S2MM));
    end
  end

  // Job FSM driving the AXI-Lite write channels with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= ST_IDLE;
      job                <= JOB_MM2S;
      idx                <= '0;
      job_addr           <= '0;
      job_len            <= '0;
      s_axi_lite_awaddr  <= '0;
      s_axi_lite_awvalid <= 1'b0;
      s_axi_lite_wdata   <= '0;
      s_axi_lite_wvalid  <= 1'b0;
      s_axi_lite_bready  <= 1'b0;
      mm2s_done          <= 1'b0;
      s2mm_done          <= 1'b0;
      err                <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      to_cnt             <= '0;
`endif
    end else begin
      mm2s_done <= 1'b0;
      s2mm_done <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            job                <= gnt_job;
            idx                <= '0;
            job_addr           <= gnt_addr;
            job_len            <= gnt_len;
            s_axi_lite_awaddr  <= gnt_wr.addr;
            s_axi_lite_wdata   <= gnt_wr.data;
            s_axi_lite_awvalid <= 1'b1;
            s_axi_lite_wvalid  <= 1'b1;
            state              <= ST_WR;
          end
        end
        ST_WR: begin
          if (s_axi_lite_awready) s_axi_lite_awvalid <= 1'b0;
          if (s_axi_lite_wready)  s_axi_lite_wvalid  <= 1'b0;
          if (aw_acc && w_acc) begin
            s_axi_lite_bready <= 1'b1;
            state             <= ST_RESP;
`ifdef DMA_TIMEOUT_EN
            to_cnt            <= '0;
`endif
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            s_axi_lite_bready <= 1'b0;
            if (s_axi_lite_bresp != 2'b00) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else if (idx != job_last(job)) begin
              idx                <= idx + 2'd1;
              s_axi_lite_awaddr  <= nxt_wr.addr;
              s_axi_lite_wdata   <= nxt_wr.data;
              s_axi_lite_awvalid <= 1'b1;
              s_axi_lite_wvalid  <= 1'b1;
              state              <= ST_WR;
            end else begin
              state <= ST_DONE;
            end
          end
`ifdef DMA_TIMEOUT_EN
          else if (to_cnt == TIMEOUT_CYCLES - 1) begin
            s_axi_lite_bready <= 1'b0;
            err               <= 1'b1;
            state             <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
`endif
        end
        default: begin
          mm2s_done <= (job == JOB_MM2S);
          s2mm_done <= (job == JOB_S2MM);
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_lite_scheduler.sv
// Directed self-checking bench for dma_lite_scheduler with a small AXI-Lite
// slave whose W-ready lag, B latency and error response are programmable.
module tb_dma_lite_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        mm2s_req, s2mm_req, mm2s_done, s2mm_done;
  logic [31:0] mm2s_addr, s2mm_addr;
  logic [25:0] mm2s_len, s2mm_len;
  logic        mm2s_introut, s2mm_introut, busy, err;
  logic [9:0]  awaddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata;
  logic [1:0]  bresp;

  int total = 0;
  int bad   = 0;

  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  int w_lag, b_lag, bad_b, b_num, wc, bc;
  int err_cnt, md_cnt, sd_cnt;

  always #5 clk = ~clk;

  dma_lite_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .mm2s_req           (mm2s_req),
    .mm2s_addr          (mm2s_addr),
    .mm2s_len           (mm2s_len),
    .mm2s_done          (mm2s_done),
    .s2mm_req           (s2mm_req),
    .s2mm_addr          (s2mm_addr),
    .s2mm_len           (s2mm_len),
    .s2mm_done          (s2mm_done),
    .mm2s_introut       (mm2s_introut),
    .s2mm_introut       (s2mm_introut),
    .busy               (busy),
    .err                (err),
    .s_axi_lite_awaddr  (awaddr),
    .s_axi_lite_awvalid (awvalid),
    .s_axi_lite_awready (awready),
    .s_axi_lite_wdata   (wdata),
    .s_axi_lite_wvalid  (wvalid),
    .s_axi_lite_wready  (wready),
    .s_axi_lite_bresp   (bresp),
    .s_axi_lite_bvalid  (bvalid),
    .s_axi_lite_bready  (bready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // Slave model and transaction log, evaluated once per negedge.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    wc = 0; bc = 0;
    forever begin
      @(negedge clk);
      awready = 1'b1;
      if (wvalid) begin
        if (wc >= w_lag) wready = 1'b1;
        else begin wready = 1'b0; wc++; end
      end else begin
        wready = 1'b0; wc = 0;
      end
      if (bready) begin
        if (bc >= b_lag) begin
          bvalid = 1'b1;
          bresp  = (b_num == bad_b) ? 2'b10 : 2'b00;
        end else begin
          bvalid = 1'b0; bc++;
        end
      end else begin
        bvalid = 1'b0; bresp = 2'b00; bc = 0;
      end
      if (awvalid && awready) aw_q.push_back({22'd0, awaddr});
      if (wvalid && wready)   w_q.push_back(wdata);
      if (bvalid && bready)   b_num++;
      if (err)       err_cnt++;
      if (mm2s_done) md_cnt++;
      if (s2mm_done) sd_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    mm2s_req = 1'b0; s2mm_req = 1'b0;
    mm2s_introut = 1'b0; s2mm_introut = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    aw_q.delete(); w_q.delete();
    w_lag = 0; b_lag = 0; bad_b = -1; b_num = 0;
    err_cnt = 0; md_cnt = 0; sd_cnt = 0;
  endtask

  // Count negedges until the selected pulse (0 mm2s_done, 1 s2mm_done, 2 err).
  task automatic wait_pulse(input int sel, input int max, output int cyc);
    logic hit;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < max) begin
      @(negedge clk);
      cyc++;
      hit = (sel == 0) ? mm2s_done : (sel == 1) ? s2mm_done : err;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL wait%0d: no pulse within %0d cycles", sel, max);
    end
  endtask

  task automatic wait_bready(input int max);
    int n;
    n = 0;
    while (!bready && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!bready) begin
      total++; bad++;
      $display("FAIL wait_bready: bready low after %0d cycles", max);
    end
  endtask

  logic [31:0] ea[4];
  logic [31:0] ed[4];
  int cyc, nd, n;

  initial begin
    mm2s_addr = '0; mm2s_len = '0; s2mm_addr = '0; s2mm_len = '0;
    w_lag = 0; b_lag = 0; bad_b = -1; b_num = 0;
    err_cnt = 0; md_cnt = 0; sd_cnt = 0;

    // Reset state and single MM2S job with an always-ready slave.
    do_reset();
    chk("rst_ctl", {25'd0, busy, awvalid, wvalid, bready, mm2s_done, s2mm_done, err}, 32'd0);
    chk("rst_awaddr", {22'd0, awaddr}, 32'd0);
    mm2s_addr = 32'h1000_0000; mm2s_len = 26'h400; mm2s_req = 1'b1;
    wait_pulse(0, 50, cyc);
    chk("t1_latency", cyc, 32'd10);
    mm2s_req = 1'b0;
    @(negedge clk);
    chk("t1_pulse_width", {31'd0, mm2s_done}, 32'd0);
    repeat (2) @(negedge clk);
    ea = '{32'h00, 32'h18, 32'h1C, 32'h28};
    ed = '{32'h0001_1003, 32'h1000_0000, 32'h0, 32'h400};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_aw%0d", i), qget(aw_q, i), ea[i]);
      chk($sformatf("t1_w%0d", i), qget(w_q, i), ed[i]);
    end
    chk("t1_nwrites", aw_q.size(), 32'd4);
    chk("t1_s2mm_done", sd_cnt, 32'd0);

    // Both requests held: alternating grants, no interleaving.
    do_reset();
    mm2s_addr = 32'hA000_0000; mm2s_len = 26'h10;
    s2mm_addr = 32'hB000_0000; s2mm_len = 26'h20;
    mm2s_req = 1'b1; s2mm_req = 1'b1;
    nd = 0; n = 0;
    while (nd < 4 && n < 200) begin
      @(negedge clk);
      n++;
      nd += int'(mm2s_done) + int'(s2mm_done);
    end
    mm2s_req = 1'b0; s2mm_req = 1'b0;
    chk("t2_jobs", nd, 32'd4);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      ea = (j % 2 == 0) ? '{32'h00, 32'h18, 32'h1C, 32'h28} : '{32'h30, 32'h48, 32'h4C, 32'h58};
      for (int k = 0; k < 4; k++)
        chk($sformatf("t2_aw%0d", 4*j+k), qget(aw_q, 4*j+k), ea[k]);
    end
    chk("t2_s2mm_addr", qget(w_q, 5), 32'hB000_0000);
    chk("t2_s2mm_len", qget(w_q, 7), 32'h20);
    chk("t2_nwrites", aw_q.size(), 32'd16);

    // S2MM interrupt during an MM2S job: clear write precedes S2MM programming.
    do_reset();
    mm2s_addr = 32'h2000_0000; mm2s_len = 26'h80;
    s2mm_addr = 32'h3000_0000; s2mm_len = 26'h90;
    mm2s_req = 1'b1;
    repeat (3) @(negedge clk);
    s2mm_introut = 1'b1; s2mm_req = 1'b1;
    wait_pulse(0, 50, cyc);
    mm2s_req = 1'b0;
    wait_pulse(1, 80, cyc);
    s2mm_req = 1'b0; s2mm_introut = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_clr_addr", qget(aw_q, 4), 32'h34);
    chk("t3_clr_data", qget(w_q, 4), 32'h1000);
    chk("t3_next_addr", qget(aw_q, 5), 32'h30);
    chk("t3_nwrites", aw_q.size(), 32'd9);
    chk("t3_s2mm_done", sd_cnt, 32'd1);

    // Slow W acceptance and delayed B response.
    do_reset();
    mm2s_addr = 32'h4000_0000; mm2s_len = 26'h3FF_FFFF;
    w_lag = 3; b_lag = 5;
    mm2s_req = 1'b1;
    @(negedge clk);
    chk("t4_n1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    @(negedge clk);
    chk("t4_n2_valids", {30'd0, awvalid, wvalid}, 32'd1);
    repeat (2) @(negedge clk);
    chk("t4_n4_wvalid", {31'd0, wvalid}, 32'd1);
    chk("t4_n4_wdata", wdata, 32'h0001_1003);
    chk("t4_n4_bready", {31'd0, bready}, 32'd0);
    @(negedge clk);
    chk("t4_n5_wb", {30'd0, wvalid, bready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t4_n10_bready", {31'd0, bready}, 32'd1);
    @(negedge clk);
    chk("t4_n11_state", {30'd0, bready, awvalid}, 32'd1);
    chk("t4_n11_awaddr", {22'd0, awaddr}, 32'h18);
    wait_pulse(0, 200, cyc);
    mm2s_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_len", qget(w_q, 3), 32'h03FF_FFFF);
    chk("t4_nwrites", aw_q.size(), 32'd4);

    // Error response on the second write aborts the job but still signals done.
    do_reset();
    bad_b = 1;
    mm2s_req = 1'b1;
    wait_pulse(0, 100, cyc);
    mm2s_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_err_cnt", err_cnt, 32'd1);
    chk("t5_nwrites", aw_q.size(), 32'd2);
    chk("t5_done_cnt", md_cnt, 32'd1);

`ifdef DMA_TIMEOUT_EN
    // B never arrives: err after the full wait budget, done follows.
    do_reset();
    b_lag = 100000;
    mm2s_req = 1'b1;
    wait_bready(20);
    wait_pulse(2, 400, cyc);
    chk("t5_timeout_cyc", cyc, 32'd256);
    wait_pulse(0, 5, cyc);
    mm2s_req = 1'b0;
    chk("t5_timeout_bready", {31'd0, bready}, 32'd0);
`endif

    // Reset while waiting for B, then a fresh job restarts at the CR write.
    do_reset();
    b_lag = 5;
    mm2s_addr = 32'h5000_0000; mm2s_len = 26'h44;
    mm2s_req = 1'b1;
    wait_bready(20);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_ctl", {25'd0, busy, awvalid, wvalid, bready, mm2s_done, s2mm_done, err}, 32'd0);
    chk("t6_rst_wdata", wdata, 32'd0);
    mm2s_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    aw_q.delete(); w_q.delete();
    b_lag = 0;
    mm2s_req = 1'b1;
    wait_pulse(0, 50, cyc);
    mm2s_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_first_addr", qget(aw_q, 0), 32'h00);
    chk("t6_first_data", qget(w_q, 0), 32'h0001_1003);
    chk("t6_nwrites", aw_q.size(), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dma_lite_scheduler.md
Name: dma_lite_scheduler

Overview:
- Single AXI-Lite write master that owns the AXI DMA control port and shares it between three kinds of requester: MM2S channel programming, S2MM channel programming, and interrupt clears for both channels.
- Each programming job is a fixed 4-register write sequence. A clear job is 1 register write.
- Unlike the fixed-count writer, every write waits for the real AW/W/B handshakes.
- Sits between the layer-control FSM and the AXI DMA s_axi_lite slave.

Parameters:
- CR_DATA, 32'h00011003, value written to MM2S_DMACR/S2MM_DMACR.
- IRQ_CLR_DATA, 32'h00001000, W1C value written to the channel status register to clear IOC.
- TIMEOUT_CYCLES, 256, B-wait limit (used only with DMA_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- mm2s_req  in  1  MM2S programming request; level, held until mm2s_done.
- mm2s_addr  in  32  source address, sampled at grant.
- mm2s_len  in  26  byte length, sampled at grant.
- mm2s_done  out  1  1-cycle pulse when the MM2S job completes.
- s2mm_req  in  1  S2MM programming request; level, held until s2mm_done.
- s2mm_addr  in  32  destination address, sampled at grant.
- s2mm_len  in  26  byte length, sampled at grant.
- s2mm_done  out  1  1-cycle pulse when the S2MM job completes.
- mm2s_introut  in  1  DMA MM2S interrupt, level.
- s2mm_introut  in  1  DMA S2MM interrupt, level.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  1-cycle pulse on bresp!=0 (or on timeout).
- s_axi_lite_awaddr  out  10  write address.
- s_axi_lite_awvalid  out  1  write address valid.
- s_axi_lite_awready  in  1  write address ready.
- s_axi_lite_wdata  out  32  write data.
- s_axi_lite_wvalid  out  1  write data valid.
- s_axi_lite_wready  in  1  write data ready.
- s_axi_lite_bresp  in  2  write response code.
- s_axi_lite_bvalid  in  1  write response valid.
- s_axi_lite_bready  out  1  write response ready.

Behaviour:
- Reset (rst==0 at a clk edge): all outputs 0, FSM to IDLE, interrupt-pending flags and round-robin pointer cleared. Any in-flight AXI write is abandoned with no cleanup.
- Interrupt capture: a rising edge of mm2s_introut/s2mm_introut sets irq_pend_mm2s/irq_pend_s2mm.
  - The flag is cleared when its clear write completes.
  - An edge arriving in the same cycle as the clear completion wins, so the flag stays set.
- Arbitration happens in IDLE only, in this priority order:
  1. irq_pend_mm2s.
  2. irq_pend_s2mm.
  3. Programming requests, round-robin between mm2s_req and s2mm_req. The pointer flips to the other channel after each granted programming job.
- Address and length are latched into job registers at grant.
- MM2S sequence: 0x00 CR_DATA; 0x18 addr; 0x1C 0; 0x28 {6'b0,len}.
- S2MM sequence: 0x30 CR_DATA; 0x48 addr; 0x4C 0; 0x58 {6'b0,len}.
- Clear writes: 0x04 or 0x34, data IRQ_CLR_DATA.
- FSM states: IDLE, WR, RESP, DONE.
  - IDLE -> WR at grant. awaddr/wdata are loaded and awvalid, wvalid are set, all on the same edge.
  - WR: awvalid drops on the edge after awready. wvalid drops on the edge after wready; the two are independent and either order is legal. Once both have been accepted: bready=1, go to RESP.
  - RESP: on bvalid&&bready, bready drops.
    - bresp!=0: pulse err, abort the job, go to DONE. The done pulse still fires so the requester is not hung.
    - Otherwise, if more writes remain: increment the index, load the next addr/data, go to WR.
    - Otherwise: go to DONE.
  - DONE: pulse the matching done (none for clear jobs), go to IDLE.
- Timing, with the slave always ready: 2 cycles per write; a 4-write job is 1 grant + 8 + 1 DONE = 10 cycles from request to done.
- awaddr/wdata are stable while the corresponding valid is high.
- A request dropped before grant is ignored. Dropping it mid-job is illegal.

Optional Feature:
- Macro: DMA_TIMEOUT_EN.
- Defined: a counter runs in RESP. When it reaches TIMEOUT_CYCLES with no bvalid:
  - drop bready;
  - pulse err;
  - go to DONE (done still pulses for programming jobs).
- Not defined: no counter; RESP waits forever.

Decomposition:
- Package dma_lite_pkg holds:
  - register offset localparams (MM2S_CR, MM2S_SR, MM2S_SA, MM2S_SA_MSB, MM2S_LENGTH, S2MM_CR, S2MM_SR, S2MM_DA, S2MM_DA_MSB, S2MM_LENGTH);
  - FSM state encoding;
  - job-type encoding (JOB_MM2S, JOB_S2MM, JOB_CLR_MM2S, JOB_CLR_S2MM).
- Sub-module dma_lite_rr_arb: the priority + 2-way round-robin grant logic.

Test Plan:
1. mm2s_req=1, addr=32'h1000_0000, len=32'h400, slave always ready -> AW writes in order 0x00/0x11003, 0x18/0x1000_0000, 0x1C/0, 0x28/0x400; mm2s_done pulse exactly 10 cycles after the request.
2. mm2s_req and s2mm_req asserted together, twice in a row -> grant order MM2S, S2MM, MM2S, S2MM; jobs never interleave.
3. s2mm_introut rises during an MM2S job -> after mm2s_done, write 0x34/0x1000 precedes any pending s2mm programming; no s2mm_done for the clear.
4. awready 3 cycles ahead of wready, and bvalid delayed by 5 cycles -> each valid drops independently after its own handshake; bready held high until bvalid; data unchanged.
5. bresp=2'b10 on the second write -> err pulses, no further writes, done pulses; with DMA_TIMEOUT_EN and bvalid never asserted -> err after 256 cycles in RESP.
6. rst low mid-RESP -> all outputs 0 the next cycle; a fresh request afterwards restarts from the CR write.
